// File: rtl/seven_seg_pkg.sv
// Shared constants and the digit record for the seven-segment scanner.
package seven_seg_pkg;

    localparam logic [1:0] MODE_OFF = 2'd0;
    localparam logic [1:0] MODE_DEC = 2'd1;
    localparam logic [1:0] MODE_RAW = 2'd3;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEL_W      = 2;

    typedef struct packed {
        logic [7:0] value;
        logic [1:0] mode;
    } digit_t;

    // A decimal zero is the only digit that can take part in leading-zero blanking.
    function automatic logic is_dec_zero(digit_t d);
        return (d.mode == MODE_DEC) && (d.value == 8'd0);
    endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Register-write and display-output bundle between host and scanner.
interface seven_seg_scanner_if;
    import seven_seg_pkg::*;

    logic                  wr_en;
    logic [SEL_W-1:0]      wr_addr;
    logic [7:0]            wr_data;
    logic [1:0]            wr_mode;
    logic                  lzb;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic [SEL_W-1:0]      sel;
    logic [7:0]            number;
    logic [1:0]            en;
    logic                  tick;

    modport master (
        output wr_en, wr_addr, wr_data, wr_mode, lzb, blink_mask,
        input  sel, number, en, tick
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_mode, lzb, blink_mask,
        output sel, number, en, tick
    );

endinterface

// File: rtl/seven_seg_tick_gen.sv
// Modulo-DIV counter advanced by adv; wrap pulses while adv is high at the terminal count.
module seven_seg_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic adv,
    output logic wrap
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          at_last;

    assign at_last = (cnt_q == LAST);
    assign wrap    = adv && at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (adv) begin
            cnt_q <= at_last ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit time-multiplexing front end: digit register file, anode scan,
// leading-zero blanking and per-digit blink feeding a registered decoder interface.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_TICKS = 256
) (
    input  logic                clk,
    input  logic                rst,
    seven_seg_scanner_if.slave  bus
);

    digit_t                digits_q [NUM_DIGITS];
    logic [SEL_W-1:0]      sel_q;
    logic                  blink_phase_q;
    logic [7:0]            number_q;
    logic [1:0]            en_q;
    logic                  tick;
    logic                  blink_wrap;
    logic [NUM_DIGITS-1:0] blank;
    logic                  chain;
    logic                  hide;

    seven_seg_tick_gen #(
        .DIV (REFRESH_DIV)
    ) u_refresh (
        .clk  (clk),
        .rst  (rst),
        .adv  (1'b1),
        .wrap (tick)
    );

    seven_seg_tick_gen #(
        .DIV (BLINK_TICKS)
    ) u_blink (
        .clk  (clk),
        .rst  (rst),
        .adv  (tick),
        .wrap (blink_wrap)
    );

    // Blanking runs from the leftmost digit down; any non-zero, raw or off digit ends it.
    always_comb begin
        blank = '0;
        chain = bus.lzb;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            chain    = chain && is_dec_zero(digits_q[i]);
            blank[i] = chain;
        end
    end

    assign hide = blank[sel_q] || (bus.blink_mask[sel_q] && blink_phase_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits_q[i] <= '{value: 8'd0, mode: MODE_OFF};
            end
        end else if (bus.wr_en) begin
            digits_q[bus.wr_addr] <= '{value: bus.wr_data, mode: bus.wr_mode};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q         <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            if (tick) begin
                sel_q <= sel_q + SEL_W'(1);
            end
            if (blink_wrap) begin
                blink_phase_q <= ~blink_phase_q;
            end
        end
    end

    // Registered on purpose: number/en trail sel by one cycle, invisible at scan rates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            number_q <= 8'd0;
            en_q     <= MODE_OFF;
        end else begin
            number_q <= digits_q[sel_q].value;
            en_q     <= hide ? MODE_OFF : digits_q[sel_q].mode;
        end
    end

    assign bus.sel    = sel_q;
    assign bus.number = number_q;
    assign bus.en     = en_q;
    assign bus.tick   = tick;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench: a cycle-count model predicts every output register update.
module tb_seven_seg_scanner;
    import seven_seg_pkg::*;

    localparam int unsigned DIV   = 4;
    localparam int unsigned BLINK = 2;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] num;
        logic [1:0] en;
        logic       tick;
    } exp_t;

    logic clk;
    logic rst;
    seven_seg_scanner_if bus_if ();

    seven_seg_scanner #(
        .REFRESH_DIV (DIV),
        .BLINK_TICKS (BLINK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    exp_t        sb_q [$];
    int unsigned k;
    logic [7:0]  m_val  [4];
    logic [1:0]  m_mode [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp_v);
        end
    endtask

    // Blanked when every digit from s up to the leftmost is a decimal zero.
    function automatic bit model_blanked(int s, bit lzb_v);
        if (!lzb_v || s == 0) return 1'b0;
        for (int j = s; j < 4; j++) begin
            if (!(m_mode[j] == 2'd1 && m_val[j] == 8'd0)) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference model: state derived from the number of edges k since reset release.
    initial begin
        exp_t e;
        int   s;
        bit   phase;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                k = 0;
                for (int i = 0; i < 4; i++) begin
                    m_val[i]  = 8'd0;
                    m_mode[i] = 2'd0;
                end
                sb_q.delete();
            end else begin
                s     = int'((k / DIV) % 4);
                phase = ((k / DIV) / BLINK) % 2 == 1;
                e.num = m_val[s];
                e.en  = (model_blanked(s, bus_if.lzb) || (bus_if.blink_mask[s] && phase))
                        ? 2'd0 : m_mode[s];
                if (bus_if.wr_en) begin
                    m_val[bus_if.wr_addr]  = bus_if.wr_data;
                    m_mode[bus_if.wr_addr] = bus_if.wr_mode;
                end
                k++;
                e.sel  = 2'((k / DIV) % 4);
                e.tick = (k % DIV) == DIV - 1;
                sb_q.push_back(e);
            end
        end
    end

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst || sb_q.size() == 0) begin
                e = '{sel: 2'd0, num: 8'd0, en: 2'd0, tick: 1'b0};
            end else begin
                e = sb_q.pop_front();
            end
            check("sel",    int'(bus_if.sel),    int'(e.sel));
            check("number", int'(bus_if.number), int'(e.num));
            check("en",     int'(bus_if.en),     int'(e.en));
            check("tick",   int'(bus_if.tick),   int'(e.tick));
        end
    end

    task automatic wr(input int a, input int d, input int m);
        @(negedge clk);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_addr = 2'(a);
        bus_if.wr_data = 8'(d);
        bus_if.wr_mode = 2'(m);
        @(negedge clk);
        bus_if.wr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load4(input int d3, input int d2, input int d1, input int d0, input int m);
        wr(3, d3, m);
        wr(2, d2, m);
        wr(1, d1, m);
        wr(0, d0, m);
    endtask

    initial begin
        int budget;
        rst               = 1'b1;
        bus_if.wr_en      = 1'b0;
        bus_if.wr_addr    = '0;
        bus_if.wr_data    = '0;
        bus_if.wr_mode    = '0;
        bus_if.lzb        = 1'b0;
        bus_if.blink_mask = '0;
        #23;
        rst = 1'b0;

        // Scan sequence and plain decimal display.
        idle(20);
        load4(1, 2, 3, 4, 1);
        idle(40);

        // Leading-zero blanking, then a nonzero digit in the middle breaks the chain.
        bus_if.lzb = 1'b1;
        load4(0, 0, 0, 7, 1);
        idle(20);
        wr(2, 5, 1);
        idle(20);

        // All zeros shows a single "0"; a raw digit on the left stops blanking.
        load4(0, 0, 0, 0, 1);
        idle(20);
        wr(3, 8'hBF, 3);
        idle(20);

        // Blink digit 1 only.
        bus_if.lzb        = 1'b0;
        bus_if.blink_mask = 4'b0010;
        load4(1, 2, 3, 4, 1);
        idle(80);
        bus_if.blink_mask = 4'b0000;

        // Mode 2 is stored and displays its raw code value.
        wr(1, 8'h33, 2);
        idle(16);

        // Asynchronous reset in the middle of slot 2.
        budget = 0;
        while (bus_if.sel != 2'd2 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("reach_sel2", int'(bus_if.sel), 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_sel",    int'(bus_if.sel),    0);
        check("async_number", int'(bus_if.number), 0);
        check("async_en",     int'(bus_if.en),     0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle(24);

        // Randomised writes and control changes.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                bus_if.wr_en   = 1'b1;
                bus_if.wr_addr = 2'($urandom_range(0, 3));
                bus_if.wr_data = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
                bus_if.wr_mode = 2'($urandom_range(0, 3));
            end else begin
                bus_if.wr_en = 1'b0;
            end
            if ($urandom_range(0, 31) == 0) bus_if.lzb = 1'($urandom);
            if ($urandom_range(0, 31) == 0) bus_if.blink_mask = 4'($urandom);
        end
        bus_if.wr_en = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
